// File: rtl/ttc_cmd_serializer.sv
// RD53B TTC command-stream serializer: 16-bit frames out MSB-first,
// idle fill and periodic sync. Ports: clk, reset_n, enable, frame_data/valid/ready, ser_ttc_data, frame_start, sync_sent, busy.
module ttc_cmd_serializer #(
  parameter int          SYNC_INTERVAL = 32,
  parameter logic [15:0] SYNC_WORD     = 16'h817E,
  parameter logic [15:0] IDLE_WORD     = 16'hAAAA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        ser_ttc_data,
  output logic        frame_start,
  output logic        sync_sent,
  output logic        busy
);

  localparam int SCW = $clog2(SYNC_INTERVAL);
  localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_INTERVAL - 1);

  localparam logic [0:0] ST_DIS = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [15:0]    sreg_q, sreg_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
  logic           frame_start_q, frame_start_d;
  logic           sync_sent_q, sync_sent_d;

  logic        last_bit;
  logic        sync_due;
  logic        load;
  logic [15:0] load_word;

  assign last_bit = (bit_cnt_q == 4'd15);
  assign sync_due = (sync_cnt_q == SYNC_LAST);

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    bit_cnt_d     = bit_cnt_q;
    sync_cnt_d    = sync_cnt_q;
    frame_start_d = 1'b0;
    sync_sent_d   = 1'b0;
    load          = 1'b0;
    load_word     = IDLE_WORD;

    case (state_q)
      ST_DIS: begin
        sreg_d    = '0;
        bit_cnt_d = '0;
        if (enable) begin
          load      = 1'b1;
          load_word = SYNC_WORD;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        sreg_d    = {sreg_q[14:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (last_bit) begin
          // Disable only takes effect here, so the
          // frame in flight always completes.
          if (!enable) begin
            state_d   = ST_DIS;
            sreg_d    = '0;
            bit_cnt_d = '0;
          end else begin
            load = 1'b1;
            if (sync_due)
              load_word = SYNC_WORD;
            else if (frame_valid)
              load_word = frame_data;
            else
              load_word = IDLE_WORD;
          end
        end
      end
      default: state_d = ST_DIS;
    endcase

    if (load) begin
      sreg_d        = load_word;
      bit_cnt_d     = '0;
      frame_start_d = 1'b1;
      // A user-supplied sync word also restarts the interval.
      if (load_word == SYNC_WORD) begin
        sync_cnt_d  = '0;
        sync_sent_d = 1'b1;
      end else begin
        sync_cnt_d  = sync_cnt_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_DIS;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      sync_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      sync_sent_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      frame_start_q <= frame_start_d;
      sync_sent_q   <= sync_sent_d;
    end
  end

  assign frame_ready  = (state_q == ST_RUN) & last_bit
                      & enable & ~sync_due;
  assign ser_ttc_data = sreg_q[15];
  assign frame_start  = frame_start_q;
  assign sync_sent    = sync_sent_q;
  assign busy         = (state_q == ST_RUN);

endmodule

// File: doc/ttc_cmd_serializer.md
# ttc_cmd_serializer

DAQ-side RD53B command-stream transmitter: the counterpart of the emulator's serial TTC input. It accepts 16-bit command frames over a valid/ready handshake and serializes them MSB-first at one bit per `clk` (160 Mb/s at 160 MHz). It fills empty slots with idle frames and forces a sync frame at a fixed frame interval. It drives `ser_ttc_data` of the emulator directly in loopback benches and feeds the differential TTC output buffer in hardware test fixtures.

## Interface
Parameters:
- `SYNC_INTERVAL`, 32: maximum frame slots between sync frame starts; must be ≥2.
- `SYNC_WORD`, 16'h817E: RD53B sync frame.
- `IDLE_WORD`, 16'hAAAA: filler frame (PLL-lock pattern).

Ports:
- `clk`  in  1: 160 MHz logic clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: stream enable; sampled only at frame boundaries.
- `frame_data`  in  16: command frame, bit 15 sent first.
- `frame_valid`  in  1: `frame_data` is valid.
- `frame_ready`  out  1: slot available; a transfer occurs when `frame_valid & frame_ready`.
- `ser_ttc_data`  out  1: serial command stream.
- `frame_start`  out  1: high during the cycle the MSB of each frame is on `ser_ttc_data`.
- `sync_sent`  out  1: coincident with `frame_start` when the frame equals `SYNC_WORD`.
- `busy`  out  1: state is RUN.

## Operation
- Datapath:
  - 16-bit shift register `sreg`; `ser_ttc_data = sreg[15]`, driven directly from the register.
  - 4-bit `bit_cnt`.
  - Sync counter `sync_cnt`, width `$clog2(SYNC_INTERVAL)`.
- State DISABLED:
  - `sreg` = 0, `bit_cnt` = 0, `frame_ready` = 0.
  - When `enable` = 1: load `SYNC_WORD`, `bit_cnt` ← 0, `sync_cnt` ← 0, go to RUN.
- State RUN:
  - Each edge: shift `sreg` left with zero fill, `bit_cnt` increments.
  - At `bit_cnt` = 15 (last bit) the next edge is a frame boundary. Selection priority:
    1. `enable` = 0: go to DISABLED, `sreg` ← 0. The frame in flight is never truncated.
    2. `sync_cnt` = `SYNC_INTERVAL-1`: load `SYNC_WORD`.
    3. `frame_valid`: load `frame_data` (accepted).
    4. Otherwise: load `IDLE_WORD`.
- `frame_ready` (combinational from state and counters, independent of `frame_valid`): RUN, `bit_cnt` = 15, `enable` = 1, `sync_cnt` ≠ `SYNC_INTERVAL-1`. At most one transfer per frame.
- `sync_cnt` update on every load:
  - Loaded word == `SYNC_WORD` (forced or user-supplied): reset to 0.
  - Otherwise: increment.
  - It never exceeds `SYNC_INTERVAL-1`, so a sync frame starts at least every `SYNC_INTERVAL` slots.
- `frame_start` and `sync_sent` are registers set on the load edge and cleared on the next edge.

## Timing
- Reset (asynchronous, immediate): state DISABLED; `ser_ttc_data`, `frame_ready`, `frame_start`, `sync_sent`, `busy` all 0; counters 0. Reset mid-frame drops the frame; nothing is accepted.
- Enable latency: `enable` sampled high at edge E in DISABLED → sync MSB on `ser_ttc_data` in the cycle after E.
- Handshake latency: transfer at edge N → MSB of `frame_data` on `ser_ttc_data` in the cycle after N. LSB appears 15 cycles later. The next boundary is edge N+16.
- Frame period: exactly 16 cycles; back-to-back frames have no gap bits.
- Throughput: at most `SYNC_INTERVAL-1` user frames per `SYNC_INTERVAL` slots.
- Boundary cases:
  - `frame_valid` held through a forced-sync slot: not accepted. It is accepted at the next slot with data unchanged.
  - `enable` deasserted at `bit_cnt` = 15 with valid high: no transfer.
- `frame_valid` and `frame_data` must stay stable until the transfer occurs.

## Test plan
- Reset/idle: hold `reset_n` = 0 for 10 cycles, release with `enable` = 0, run 100 cycles → all outputs 0 throughout; `frame_ready` never high.
- Idle stream: `enable` = 1, `frame_valid` = 0 → first 16 bits 1000000101111110 with `sync_sent` pulse, then 31 frames of 1010…10, then sync again (frame starts 16·32 cycles apart).
- Single frame: after enable, present 16'h6969 with valid held → `frame_ready` high for exactly one cycle at the end of the sync frame; next 16 bits are 0110100101101001; subsequent frames are 0xAAAA.
- Saturation: 100 sequential words 16'h0001..16'h0064 with valid always high → sync at slots 0, 32, 64, 96 with `frame_ready` low in those slots; all 100 words emitted in order, none lost or duplicated.
- Disable mid-frame: deassert `enable` at `bit_cnt` = 7 → remaining 8 bits still emitted, then `ser_ttc_data` = 0 and `busy` = 0. Re-enable → stream restarts with `SYNC_WORD` and `sync_cnt` = 0.
- Async reset mid-frame: drop `reset_n` at `bit_cnt` = 5 between edges → outputs 0 before the next edge; after release with `enable` = 1 the stream restarts with a sync frame.
